// File: rtl/packet_framer_pkg.sv
// packet_framer_pkg: shared types and CRC16-USB constants for the packet framer
package packet_framer_pkg;
  typedef enum logic [2:0] {
    SEL_PID     = 3'b001,
    SEL_PID_CRC = 3'b010,
    SEL_DATA    = 3'b011,
    SEL_ENC     = 3'b100
  } sel_e;
  typedef enum logic [2:0] {S_IDLE, S_PID, S_PAYLOAD, S_CRC_LO, S_CRC_HI} state_e;
  localparam logic [15:0] CRC16_POLY_R = 16'hA001;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
  function automatic logic sel_legal(input logic [2:0] s);
    return s inside {SEL_PID, SEL_PID_CRC, SEL_DATA, SEL_ENC};
  endfunction
endpackage

// File: rtl/packet_framer_crc16_byte.sv
// crc16_byte: combinational byte-wide CRC16-USB update (reflected, LSB first)
// Ports: crc_i running CRC, byte_i next byte, crc_o updated CRC.
// Only compiled when PACKET_FRAMER_CRC_GEN_EN is defined.
`ifdef PACKET_FRAMER_CRC_GEN_EN
module crc16_byte import packet_framer_pkg::*; (
  input  logic [15:0] crc_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] crc_o
);
  logic [15:0] c;
  always_comb begin
    c = crc_i ^ {8'h00, byte_i};
    for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ CRC16_POLY_R : c >> 1;
    crc_o = c;
  end
endmodule
`endif

// File: rtl/packet_framer.sv
// packet_framer: serialises PID, optional payload and CRC into a ready/valid byte stream
// Ports: clk, n_rst (async active-low); PID_in, data_in, encrypted, CRC_in, data_sel, start
// request a packet; out_valid/out_data/out_last/out_ready form the byte stream; busy, done, err status.
// Macro PACKET_FRAMER_CRC_GEN_EN: modes 011/100 emit an internally generated CRC16-USB.
module packet_framer import packet_framer_pkg::*; #(
  parameter int PAYLOAD_BYTES = 8,
  parameter int OUT_W         = 8
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [7:0]                 PID_in,
  input  logic [8*PAYLOAD_BYTES-1:0] data_in,
  input  logic [8*PAYLOAD_BYTES-1:0] encrypted,
  input  logic [15:0]                CRC_in,
  input  logic [2:0]                 data_sel,
  input  logic                       start,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);
  localparam int CW = $clog2(PAYLOAD_BYTES + 1);
  state_e                     state_q;
  logic [2:0]                 sel_q;
  logic [7:0]                 pid_q;
  logic [8*PAYLOAD_BYTES-1:0] pay_q;
  logic [15:0]                crc_q, crc_fin;
  logic [CW-1:0]              cnt_q, cnt_nx;
  logic                       out_valid_q, out_last_q, busy_q, done_q, err_q;
  logic [OUT_W-1:0]           out_data_q;
  logic                       accept, cnt_last;
  assign accept   = out_valid_q & out_ready;
  assign cnt_nx   = cnt_q + CW'(1);
  assign cnt_last = cnt_q == CW'(PAYLOAD_BYTES - 1);
`ifdef PACKET_FRAMER_CRC_GEN_EN
  // The running CRC absorbs each payload byte as it is accepted, so the final
  // value is ready on the same edge that moves into CRC_LO.
  logic [15:0] crc_acc_q, crc_nx;
  crc16_byte u_crc (.crc_i(crc_acc_q), .byte_i(out_data_q[7:0]), .crc_o(crc_nx));
  assign crc_fin = ~crc_nx;
`else
  assign crc_fin = crc_q;
`endif
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      pid_q       <= '0;
      pay_q       <= '0;
      crc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef PACKET_FRAMER_CRC_GEN_EN
      crc_acc_q   <= CRC16_INIT;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          if (sel_legal(data_sel)) begin
            state_q     <= S_PID;
            sel_q       <= data_sel;
            pid_q       <= PID_in;
            pay_q       <= data_sel == SEL_ENC ? encrypted : data_in;
            crc_q       <= CRC_in;
            busy_q      <= 1'b1;
            out_valid_q <= 1'b1;
            out_data_q  <= PID_in;
            out_last_q  <= data_sel == SEL_PID;
`ifdef PACKET_FRAMER_CRC_GEN_EN
            crc_acc_q   <= CRC16_INIT;
`endif
          end else err_q <= 1'b1;
        end
        S_PID: if (accept) begin
          if (sel_q == SEL_PID) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b1;
          end else if (sel_q == SEL_PID_CRC) begin
            state_q    <= S_CRC_LO;
            out_data_q <= crc_q[7:0];
          end else begin
            state_q    <= S_PAYLOAD;
            cnt_q      <= '0;
            out_data_q <= pay_q[7:0];
          end
        end
        S_PAYLOAD: if (accept) begin
`ifdef PACKET_FRAMER_CRC_GEN_EN
          crc_acc_q <= crc_nx;
`endif
          if (cnt_last) begin
            state_q    <= S_CRC_LO;
            crc_q      <= crc_fin;
            out_data_q <= crc_fin[7:0];
          end else begin
            cnt_q      <= cnt_nx;
            out_data_q <= pay_q[{cnt_nx, 3'b000} +: 8];
          end
        end
        S_CRC_LO: if (accept) begin
          state_q    <= S_CRC_HI;
          out_data_q <= crc_q[15:8];
          out_last_q <= 1'b1;
        end
        S_CRC_HI: if (accept) begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          out_data_q  <= '0;
          done_q      <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
endmodule

// File: tb/tb_packet_framer.sv
// tb_packet_framer: scoreboard bench for packet_framer (PAYLOAD_BYTES=9)
module tb_packet_framer;
  localparam int PB = 9;
  logic          clk = 1'b0;
  logic          n_rst;
  logic [7:0]    PID_in;
  logic [8*PB-1:0] data_in, encrypted;
  logic [15:0]   CRC_in;
  logic [2:0]    data_sel;
  logic          start, out_ready;
  logic          out_valid, out_last, busy, done, err;
  logic [7:0]    out_data;
  logic [8:0]    exp_q[$];
  int            checks = 0, errors = 0, beats = 0;
  logic [7:0]    b_last, b_prev;
  logic          pv_stall = 1'b0, pv_last;
  logic [7:0]    pv_data;

  always #5 clk = ~clk;

  packet_framer #(.PAYLOAD_BYTES(PB), .OUT_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .PID_in(PID_in), .data_in(data_in), .encrypted(encrypted),
    .CRC_in(CRC_in), .data_sel(data_sel), .start(start), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .busy(busy),
    .done(done), .err(err)
  );

`ifdef PACKET_FRAMER_CRC_GEN_EN
  function automatic logic [15:0] crc_model(input logic [8*PB-1:0] p);
    logic [15:0] c = 16'hFFFF;
    logic fb;
    for (int i = 0; i < 8*PB; i++) begin
      fb = c[0] ^ p[i];
      c = c >> 1;
      if (fb) c = c ^ 16'hA001;
    end
    return ~c;
  endfunction
`endif

  task automatic push_pkt(input logic [2:0] sel, input logic [7:0] pid,
                          input logic [8*PB-1:0] d, input logic [8*PB-1:0] e, input logic [15:0] crc);
    logic [8*PB-1:0] p;
    logic [15:0] c = crc;
    exp_q.push_back({sel == 3'b001, pid});
    if (sel == 3'b001) return;
    if (sel == 3'b011 || sel == 3'b100) begin
      p = sel == 3'b011 ? d : e;
      for (int i = 0; i < PB; i++) exp_q.push_back({1'b0, p[8*i +: 8]});
`ifdef PACKET_FRAMER_CRC_GEN_EN
      c = crc_model(p);
`endif
    end
    exp_q.push_back({1'b0, c[7:0]});
    exp_q.push_back({1'b1, c[15:8]});
  endtask

  task automatic drive(input logic [2:0] sel, input logic [7:0] pid,
                       input logic [8*PB-1:0] d, input logic [8*PB-1:0] e, input logic [15:0] crc);
    data_sel = sel; PID_in = pid; data_in = d; encrypted = e; CRC_in = crc; start = 1'b1;
    push_pkt(sel, pid, d, e, crc);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] sel, input logic [7:0] pid,
                      input logic [8*PB-1:0] d, input logic [8*PB-1:0] e, input logic [15:0] crc);
    @(posedge clk); #1;
    drive(sel, pid, d, e, crc);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL %s_timeout: busy=%0b pending=%0d after %0d cycles, required drained", name, busy, exp_q.size(), n);
    end
  endtask

  // Beat monitor: compares every accepted beat with the scoreboard and checks
  // that a stalled beat is held unchanged.
  initial forever begin
    logic [8:0] e;
    @(negedge clk);
    if (!n_rst) pv_stall = 1'b0;
    else begin
      if (pv_stall) begin
        checks++;
        if ({out_valid, out_last, out_data} !== {1'b1, pv_last, pv_data}) begin
          errors++;
          $display("FAIL stall_hold: got v=%b l=%b d=%h, required v=1 l=%b d=%h", out_valid, out_last, out_data, pv_last, pv_data);
        end
      end
      if (out_valid && out_ready) begin
        beats++;
        b_prev = b_last;
        b_last = out_data;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat: got unexpected l=%b d=%h, required no beat", out_last, out_data);
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin
            errors++;
            $display("FAIL beat: got l=%b d=%h, required l=%b d=%h", out_last, out_data, e[8], e[7:0]);
          end
        end
      end
      pv_stall = out_valid && !out_ready;
      pv_data  = out_data;
      pv_last  = out_last;
    end
  end

  task automatic test_reset;
    n_rst = 1'b0; start = 1'b0; out_ready = 1'b1; data_sel = 3'b001;
    PID_in = '0; data_in = '0; encrypted = '0; CRC_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_data, out_last, busy, done, err} !== 13'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h l=%b b=%b dn=%b e=%b, required all 0", out_valid, out_data, out_last, busy, done, err);
    end
    n_rst = 1'b1;
  endtask

  task automatic test_pid_only;
    send(3'b001, 8'hA5, '0, '0, 16'h0);
    checks++;
    if ({out_valid, busy, out_data, out_last} !== {2'b11, 8'hA5, 1'b1}) begin
      errors++;
      $display("FAIL pid_first_beat: got v=%b b=%b d=%h l=%b, required v=1 b=1 d=a5 l=1", out_valid, busy, out_data, out_last);
    end
    drain("pid_only");
    checks++;
    if ({done, busy} !== 2'b10) begin
      errors++;
      $display("FAIL pid_done: got done=%b busy=%b, required done=1 busy=0", done, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL pid_done_pulse: got done=%b on second cycle, required 0", done);
    end
  endtask

  task automatic test_crc_payload;
    logic [8*PB-1:0] d = "987654321";
    int b0 = beats;
    send(3'b011, 8'h11, d, '0, 16'h00AB);
    drain("crc_payload");
    checks++;
    if (beats - b0 !== PB + 3) begin
      errors++;
      $display("FAIL crc_payload_beats: got %0d, required %0d", beats - b0, PB + 3);
    end
    checks++;
`ifdef PACKET_FRAMER_CRC_GEN_EN
    if ({b_prev, b_last} !== 16'hC8B4) begin
`else
    if ({b_prev, b_last} !== 16'hAB00) begin
`endif
      errors++;
      $display("FAIL crc_payload_crc: got lo=%h hi=%h", b_prev, b_last);
    end
  endtask

  task automatic test_stall_encrypted;
    logic [8*PB-1:0] e;
    int b0 = beats;
    for (int i = 0; i < PB; i++) e[8*i +: 8] = 8'($urandom_range(255));
    send(3'b100, 8'h5C, '1, e, 16'h7E81);
    for (int i = 0; i < 200; i++) begin
      out_ready = (i % 4 == 0) || (i % 4 == 3);
      if (i == 5) begin
        data_sel = 3'b010; PID_in = 8'hFF; CRC_in = 16'hBEEF; encrypted = '0; start = 1'b1;
      end else start = 1'b0;
      @(posedge clk); #1;
      if (!busy) break;
    end
    out_ready = 1'b1; start = 1'b0;
    checks++;
    if (done !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_done: got done=%b pending=%0d, required done=1 pending=0", done, exp_q.size());
    end
    checks++;
    if (beats - b0 !== PB + 3) begin
      errors++;
      $display("FAIL stall_beats: got %0d, required %0d", beats - b0, PB + 3);
    end
  endtask

  task automatic test_back_to_back;
    send(3'b010, 8'h69, '0, '0, 16'h1234);
    drain("b2b_first");
    checks++;
    if ({done, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_gap: got done=%b valid=%b, required done=1 valid=0", done, out_valid);
    end
    drive(3'b001, 8'h3C, '0, '0, 16'h0);
    checks++;
    if ({out_valid, out_data} !== {1'b1, 8'h3C}) begin
      errors++;
      $display("FAIL b2b_second_start: got v=%b d=%h, required v=1 d=3c", out_valid, out_data);
    end
    drain("b2b_second");
  endtask

  task automatic test_illegal;
    @(posedge clk); #1;
    data_sel = 3'b111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({err, busy, out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL illegal_err: got err=%b busy=%b valid=%b, required err=1 busy=0 valid=0", err, busy, out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({err, busy} !== 2'b00) begin
      errors++;
      $display("FAIL illegal_pulse: got err=%b busy=%b, required 0 0", err, busy);
    end
  endtask

  task automatic test_reset_mid_packet;
    logic saw_done = 1'b0;
    send(3'b011, 8'h42, {$urandom, $urandom, $urandom}, '0, 16'h5555);
    repeat (4) @(posedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if ({out_valid, out_data, out_last, busy, done, err} !== 13'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got v=%b d=%h l=%b b=%b dn=%b e=%b, required all 0", out_valid, out_data, out_last, busy, done, err);
    end
    @(posedge clk); #1;
    n_rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      saw_done |= done;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_done: got done pulse, required none");
    end
    send(3'b001, 8'h77, '0, '0, 16'h0);
    drain("midreset_restart");
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL midreset_restart_done: got done=%b, required 1", done);
    end
  endtask

  initial begin
    test_reset();
    test_pid_only();
    test_crc_payload();
    test_stall_encrypted();
    test_back_to_back();
    test_illegal();
    test_reset_mid_packet();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/packet_framer.md
PACKET_FRAMER -- requirements
Module: packet_framer

Interface
REQ-001 SHALL have parameter PAYLOAD_BYTES, default 8, number of payload bytes per data packet (1..64).
REQ-002 SHALL have parameter OUT_W, default 8, output beat width in bits; only 8 is supported.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 PID_in  input  8  packet ID byte.
REQ-006 data_in  input  8*PAYLOAD_BYTES  plaintext payload, byte 0 = bits [7:0].
REQ-007 encrypted  input  8*PAYLOAD_BYTES  encrypted payload, same byte order.
REQ-008 CRC_in  input  16  externally supplied CRC.
REQ-009 data_sel  input  3  packet mode: 001 PID-only; 010 PID+CRC_in; 011 PID+data_in+CRC; 100 PID+encrypted+CRC; others illegal.
REQ-010 start  input  1  one-cycle request to frame a packet.
REQ-011 out_ready  input  1  downstream accepts the current beat.
REQ-012 out_valid  output  1  out_data holds a valid beat.
REQ-013 out_data  output  8  current packet byte.
REQ-014 out_last  output  1  current beat is the final byte of the packet.
REQ-015 busy  output  1  a packet is in progress.
REQ-016 done  output  1  one-cycle pulse after the last beat is accepted.
REQ-017 err  output  1  one-cycle pulse when start arrives with an illegal data_sel.

Function
REQ-018 States: IDLE, PID, PAYLOAD, CRC_LO, CRC_HI; transitions occur only on an accepted beat (out_valid && out_ready).
REQ-019 In IDLE, start with a legal data_sel latches PID_in, the selected payload, CRC_in and data_sel, then enters PID the next cycle; busy rises the same cycle.
REQ-020 start with an illegal data_sel pulses err for one cycle and the block stays IDLE.
REQ-021 start while busy is ignored; latched fields are not altered.
REQ-022 First beat: out_valid high one cycle after start; beats follow at one byte per cycle while out_ready is held high.
REQ-023 Byte order: PID, then payload bytes 0..PAYLOAD_BYTES-1, then CRC low byte, then CRC high byte.
REQ-024 Mode 001 emits 1 beat; mode 010 emits 3 beats (CRC = CRC_in); modes 011/100 emit PAYLOAD_BYTES+3 beats.
REQ-025 While out_valid && !out_ready, out_data, out_last and out_valid SHALL hold stable.
REQ-026 out_last is asserted with the final beat only; after it is accepted, the block returns to IDLE, busy falls and done pulses in the next cycle.
REQ-027 start is accepted in the cycle done pulses; back-to-back packets are then separated by exactly one idle cycle.
REQ-028 The payload byte counter is ceil(log2(PAYLOAD_BYTES+1)) bits wide and is cleared on every transition into PAYLOAD.

Reset
REQ-029 While n_rst is low: state IDLE, out_valid=0, out_data=0, out_last=0, busy=0, done=0, err=0, and all latched fields are 0.
REQ-030 Reset asserted mid-packet aborts the packet immediately; no done pulse is generated.

Configuration
REQ-031 Macro PACKET_FRAMER_CRC_GEN_EN: when defined, modes 011/100 use an internally generated CRC16-USB over the emitted payload bytes (reflected polynomial 0xA001, init 0xFFFF, final complement), and CRC_in is used only in mode 010.
REQ-032 When PACKET_FRAMER_CRC_GEN_EN is not defined, every mode carrying a CRC emits the latched CRC_in and no CRC logic is synthesized.
REQ-033 The generated CRC SHALL be complete by the time CRC_LO is entered; no extra cycles are allowed.

Structure
REQ-034 The shared package holds the data_sel mode enum, the state enum, and the constants CRC16_POLY_R=16'hA001 and CRC16_INIT=16'hFFFF.
REQ-035 The CRC is computed in sub-module crc16_byte: a combinational byte-wide update (crc_in, byte -> crc_out) instantiated only under the macro.

Verification
REQ-036 Mode 001, PID_in=8'hA5, out_ready=1 -> single beat A5 with out_last=1; done pulses one cycle later.
REQ-037 Mode 010, PID_in=8'h69, CRC_in=16'h1234 -> beats 69,34,12; out_last on 12.
REQ-038 Mode 011, PAYLOAD_BYTES=9, data_in="123456789" (byte 0 = '1'), macro defined -> CRC beats C8,B4; macro undefined with CRC_in=16'h00AB -> AB,00.
REQ-039 Mode 100, out_ready toggled 1,0,0,1 -> out_data held through stalls; beat count is PAYLOAD_BYTES+3; start pulsed mid-packet is ignored.
REQ-040 data_sel=3'b111 with start -> err pulse, busy stays 0; n_rst low during PAYLOAD -> all outputs 0 with no done pulse, and the next start frames normally.
